// File: rtl/encoder_8_to_3_seq.sv
// -----------------------------------------------------------------------------
// encoder_8_to_3_seq
//
// Sequential 8-to-3 encoder. Accepts a multi-hot request vector over a
// valid/ready handshake and drains it as a stream of binary indices, one per
// output handshake. Default order is lowest set bit first.
//
// Optional build macro:
//   ENC_MSB_FIRST_EN  when defined, indices are emitted highest set bit first;
//                     handshake, latency and err_zero behaviour are unchanged.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_vec is valid
//   in_ready   block can accept a vector (high whenever idle)
//   in_vec     request vector, bit i set = index i pending
//   out_valid  out_idx/out_last are valid
//   out_ready  consumer accepts the current index
//   out_idx    binary index of the current pending bit
//   out_last   current index is the last pending bit of this vector
//   busy       a vector is being drained
//   err_zero   one-cycle pulse after an all-zero vector is accepted
// -----------------------------------------------------------------------------
module encoder_8_to_3_seq #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 3   // 2**OUT_W must equal IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             err_zero
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state;
  logic [IN_W-1:0] pending;
  logic [IN_W-1:0] remaining;
  logic            in_fire;
  logic            out_fire;

  // Index of the next bit to emit from a vector: the lowest set bit, or the
  // highest when the MSB-first build is selected. The last hit in the loop
  // wins, so the loop direction decides the priority.
  function automatic logic [OUT_W-1:0] pick_idx(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] idx;
    idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) idx = OUT_W'(i);
    end
`else
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (v[i]) idx = OUT_W'(i);
    end
`endif
    return idx;
  endfunction

  // True when exactly one bit is set; independent of scan order because the
  // final emitted index is always the only bit left.
  function automatic logic is_single(input logic [IN_W-1:0] v);
    return (v != '0) && ((v & (v - IN_W'(1))) == '0);
  endfunction

  assign in_ready  = (state == IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // Pending bits once the index currently on the output is retired.
  assign remaining = pending & ~(IN_W'(1) << out_idx);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking would make 'remaining'/'out_idx'
  // ordering-dependent and break simulation/synthesis equivalence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err_zero  <= 1'b0;
    end else begin
      // err_zero is a pulse: cleared every cycle unless re-armed below.
      err_zero <= 1'b0;

      unique case (state)
        IDLE: begin
          if (in_fire) begin
            if (in_vec == '0) begin
              err_zero <= 1'b1;
            end else begin
              pending   <= in_vec;
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_idx   <= pick_idx(in_vec);
              out_last  <= is_single(in_vec);
              busy      <= 1'b1;
            end
          end
        end

        DRAIN: begin
          // Stalled (out_ready low): nothing changes, outputs hold.
          if (out_fire) begin
            if (out_last) begin
              pending   <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              pending  <= remaining;
              out_idx  <= pick_idx(remaining);
              out_last <= is_single(remaining);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_8_to_3_seq.sv
// -----------------------------------------------------------------------------
// tb_encoder_8_to_3_seq
//
// Self-checking bench for encoder_8_to_3_seq. Expected {out_last, out_idx}
// pairs are pushed to a scoreboard queue when a vector is driven and popped
// by a monitor on every output handshake. Honours ENC_MSB_FIRST_EN.
// -----------------------------------------------------------------------------
module tb_encoder_8_to_3_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;
  logic       err_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_count = 0;

  logic [3:0] exp_q[$];   // {last, idx}

  // Stall tracking for the hold-stable check.
  logic       stalled;
  logic [2:0] stall_idx;
  logic       stall_last;

  encoder_8_to_3_seq #(.IN_W(8), .OUT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .err_zero  (err_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: list the set bits in emission order, mark the final one.
  task automatic push_expected(input logic [7:0] v);
    int order[$];
`ifdef ENC_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) if (v[i]) order.push_back(i);
`else
    for (int i = 0; i < 8; i++) if (v[i]) order.push_back(i);
`endif
    for (int k = 0; k < order.size(); k++)
      exp_q.push_back({(k == order.size() - 1) ? 1'b1 : 1'b0, 3'(order[k])});
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) begin
        check("hold_idx", 32'(out_idx), 32'(stall_idx));
        check("hold_last", 32'(out_last), 32'(stall_last));
      end
      stalled = 1'b0;
      if (out_valid && !out_ready) begin
        stalled    = 1'b1;
        stall_idx  = out_idx;
        stall_last = out_last;
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_idx), 32'hDEAD);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("out_idx", 32'(out_idx), 32'(e[2:0]));
          check("out_last", 32'(out_last), 32'(e[3]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present vec for exactly one accept edge.
  task automatic offer(input logic [7:0] vec);
    int t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_vec   = vec;
    push_expected(vec);
    step();
    in_valid = 1'b0;
  endtask

  // Run until the scoreboard is empty and the output is idle, optionally
  // toggling out_ready every cycle starting from 1.
  task automatic drain(input bit toggle);
    int t = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      step();
      if (toggle) out_ready = ~out_ready;
      t++;
    end
    check("drain_timeout", 32'(t < 100), 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    int hs0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    stalled   = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_zero", 32'(err_zero), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single bit: one output, in_ready back the next cycle.
    offer(8'b0000_0100);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready_low", 32'(in_ready), 32'd0);
    drain(1'b0);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t1_busy_done", 32'(busy), 32'd0);

    // Three bits, back-to-back.
    hs0 = hs_count;
    offer(8'b1010_0001);
    drain(1'b0);
    check("t2_hs", 32'(hs_count - hs0), 32'd3);

    // All bits with out_ready toggling.
    hs0 = hs_count;
    offer(8'hFF);
    drain(1'b1);
    check("t3_hs", 32'(hs_count - hs0), 32'd8);

    // All-zero vector: err_zero pulse, no output.
    hs0 = hs_count;
    in_valid = 1'b1;
    in_vec   = 8'h00;
    step();
    in_valid = 1'b0;
    check("t4_err_zero", 32'(err_zero), 32'd1);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    step();
    check("t4_err_clear", 32'(err_zero), 32'd0);
    check("t4_no_out", 32'(out_valid), 32'd0);
    check("t4_hs", 32'(hs_count - hs0), 32'd0);

    // in_valid held with a new vector during DRAIN.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 8'b0011_0000;
    push_expected(8'b0011_0000);
    step();
    in_vec = 8'hAA;
    push_expected(8'hAA);
    check("t5_err_in_drain", 32'(err_zero), 32'd0);
    begin
      int t = 0;
      while (out_valid && t < 20) begin
        check("t5_hold_in_ready", 32'(in_ready), 32'd0);
        step();
        t++;
      end
    end
    // Final handshake edge just passed: idle, nothing taken on that edge.
    check("t5_gap_in_ready", 32'(in_ready), 32'd1);
    check("t5_gap_busy", 32'(busy), 32'd0);
    check("t5_pending_first", 32'(exp_q.size()), 32'd4);
    step();
    in_valid = 1'b0;
    check("t5_aa_busy", 32'(busy), 32'd1);
    drain(1'b0);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-DRAIN.
    offer(8'b1000_0011);
    out_ready = 1'b1;
    step();   // first index handshaken on this edge
    check("t6_q_left", 32'(exp_q.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    #10;
    rst_n = 1'b1;
    hs0 = hs_count;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_stale", 32'(out_valid), 32'd0);
    end
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_hs", 32'(hs_count - hs0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
